// File: rtl/mips_run_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_pkg
//  Purpose  : Shared types and constants for the MIPS run controller /
//             result checker (state enumeration, fail_code encoding).
//  Revision : 1.0 - initial release
// ============================================================================
package mips_run_pkg;

  // Width of the fail_code output
  localparam int FC_W = 2;

  // Controller states; PASS, FAIL and TIMEOUT are terminal
  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  // fail_code encoding
  localparam logic [FC_W-1:0] FC_NONE     = 2'd0;
  localparam logic [FC_W-1:0] FC_BAD_DATA = 2'd1;
  localparam logic [FC_W-1:0] FC_BAD_ADDR = 2'd2;
  localparam logic [FC_W-1:0] FC_TIMEOUT  = 2'd3;

  // True for the sticky verdict states
  function automatic logic is_terminal(input run_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : run_sat_counter
//  Purpose  : W-bit up counter with synchronous clear that sticks at
//             all-ones instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module run_sat_counter
  import mips_run_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,   // synchronous, active-low
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/mips_run_checker.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_checker
//  Purpose  : Holds the MIPS core in reset for RESET_CYCLES, then releases it
//             and judges its data-memory writes, latching a sticky PASS,
//             FAIL or TIMEOUT verdict. Re-arms on start in a terminal state.
//  Options  : RUN_CHECKER_TIMEOUT_EN - when defined, a RUN phase of
//             TIMEOUT_CYCLES cycles without a deciding write ends in TIMEOUT.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_run_checker
  import mips_run_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int PASS_ADDR      = 84,
  parameter int PASS_DATA      = 7,
  parameter int IGNORE_ADDR    = 80,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,       // synchronous, active-low
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              core_reset,
  output logic              done,
  output logic              pass,
  output logic [FC_W-1:0]   fail_code,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [DATA_W-1:0] bad_data,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  cycle_count
);

  // Hold counter only needs to reach RESET_CYCLES-1
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_W-1:0] c_PASS_ADDR = ADDR_W'(PASS_ADDR);
  localparam logic [ADDR_W-1:0] c_IGN_ADDR  = ADDR_W'(IGNORE_ADDR);
  localparam logic [DATA_W-1:0] c_PASS_DATA = DATA_W'(PASS_DATA);

  run_state_e        state_q, state_d;
  logic [FC_W-1:0]   fail_code_q, fail_code_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;
  logic [DATA_W-1:0] bad_data_q, bad_data_d;

  logic [HOLD_W-1:0] w_hold_cnt;
  logic              w_in_hold;
  logic              w_in_run;
  logic              w_terminal;
  logic              w_rearm;
  logic              w_timeout_hit;

  assign w_in_hold  = (state_q == ST_HOLD);
  assign w_in_run   = (state_q == ST_RUN);
  assign w_terminal = is_terminal(state_q);
  assign w_rearm    = w_terminal && start;

`ifdef RUN_CHECKER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  assign w_timeout_hit = (cycle_count == c_TIMEOUT_LAST);
`else
  assign w_timeout_hit = 1'b0;
`endif

  // Reset-length counter: runs only while holding, cleared otherwise
  run_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!w_in_hold),
    .en    (w_in_hold),
    .count (w_hold_cnt)
  );

  // Cycles spent in RUN; frozen in terminal states, cleared on re-arm
  run_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_rearm),
    .en    (w_in_run),
    .count (cycle_count)
  );

  // Writes seen in RUN, including the deciding one
  run_sat_counter #(.W(CNT_W)) u_write_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_rearm),
    .en    (w_in_run && memwrite),
    .count (write_count)
  );

  // Next state and verdict capture; a deciding write outranks the timeout
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    bad_addr_d  = bad_addr_q;
    bad_data_d  = bad_data_q;
    case (state_q)
      ST_HOLD: begin
        if (w_hold_cnt == c_HOLD_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (memwrite && (dataadr == c_PASS_ADDR)) begin
          if (writedata == c_PASS_DATA) begin
            state_d = ST_PASS;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = FC_BAD_DATA;
            bad_addr_d  = dataadr;
            bad_data_d  = writedata;
          end
        end else if (memwrite && (dataadr != c_IGN_ADDR)) begin
          state_d     = ST_FAIL;
          fail_code_d = FC_BAD_ADDR;
          bad_addr_d  = dataadr;
          bad_data_d  = writedata;
        end else if (w_timeout_hit) begin
          state_d     = ST_TIMEOUT;
          fail_code_d = FC_TIMEOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (start) begin
          state_d     = ST_HOLD;
          fail_code_d = FC_NONE;
          bad_addr_d  = '0;
          bad_data_d  = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // State and verdict registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_HOLD;
      fail_code_q <= FC_NONE;
      bad_addr_q  <= '0;
      bad_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      bad_addr_q  <= bad_addr_d;
      bad_data_q  <= bad_data_d;
    end
  end

  assign core_reset = w_in_hold;
  assign done       = w_terminal;
  assign pass       = (state_q == ST_PASS);
  assign fail_code  = fail_code_q;
  assign bad_addr   = bad_addr_q;
  assign bad_data   = bad_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_run_checker
//  Purpose  : Self-checking bench for mips_run_checker: directed scenarios
//             followed by randomized traffic, compared every cycle against a
//             behavioural model of the run/verdict rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_run_checker;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int RST_CYC  = 2;
  localparam int TO_CYC   = 20;
  localparam int P_ADDR   = 84;
  localparam int P_DATA   = 7;
  localparam int I_ADDR   = 80;
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef RUN_CHECKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              core_reset, done, pass;
  logic [1:0]        fail_code;
  logic [ADDR_W-1:0] bad_addr;
  logic [DATA_W-1:0] bad_data;
  logic [CNT_W-1:0]  write_count, cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_run_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_CYCLES(RST_CYC),
    .TIMEOUT_CYCLES(TO_CYC), .PASS_ADDR(P_ADDR), .PASS_DATA(P_DATA),
    .IGNORE_ADDR(I_ADDR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .core_reset(core_reset),
    .done(done), .pass(pass), .fail_code(fail_code), .bad_addr(bad_addr),
    .bad_data(bad_data), .write_count(write_count), .cycle_count(cycle_count)
  );

  // Behavioural model: phase 0 = holding, 1 = running, 2 = verdict latched
  int          m_phase;
  int          m_hold_left;
  int          m_cyc, m_wr, m_fc;
  bit          m_pass;
  int unsigned m_ba, m_bd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_hold_left = RST_CYC; m_cyc = 0; m_wr = 0;
    m_fc = 0; m_pass = 0; m_ba = 0; m_bd = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit m,
                            input int unsigned a, input int unsigned d);
    bit decided;
    int cyc_before;
    if (!r) begin
      model_clear();
    end else if (m_phase == 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_phase = 1;
    end else if (m_phase == 1) begin
      cyc_before = m_cyc;
      if (m_cyc < CNT_MAX) m_cyc++;
      decided = 1'b0;
      if (m) begin
        if (m_wr < CNT_MAX) m_wr++;
        if (a == P_ADDR) begin
          decided = 1'b1;
          m_phase = 2;
          if (d == P_DATA) m_pass = 1;
          else begin m_fc = 1; m_ba = a; m_bd = d; end
        end else if (a != I_ADDR) begin
          decided = 1'b1;
          m_phase = 2; m_fc = 2; m_ba = a; m_bd = d;
        end
      end
      if (!decided && TO_EN && cyc_before == TO_CYC - 1) begin
        m_phase = 2; m_fc = 3;
      end
    end else if (s) begin
      model_clear();
    end
  endtask

  task automatic check_all();
    chk("core_reset",  core_reset,  64'(m_phase == 0));
    chk("done",        done,        64'(m_phase == 2));
    chk("pass",        pass,        64'(m_pass));
    chk("fail_code",   fail_code,   64'(m_fc));
    chk("bad_addr",    bad_addr,    64'(m_ba));
    chk("bad_data",    bad_data,    64'(m_bd));
    chk("write_count", write_count, 64'(m_wr));
    chk("cycle_count", cycle_count, 64'(m_cyc));
  endtask

  // One clock: drive inputs, advance the model on the edge, check at negedge
  task automatic tick(input bit r, input bit s, input bit m,
                      input int unsigned a, input int unsigned d);
    reset = r; start = s; memwrite = m;
    dataadr = ADDR_W'(a); writedata = DATA_W'(d);
    @(posedge clk);
    model_step(r, s, m, a, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask

  task automatic rearm();
    tick(1, 1, 0, 0, 0);
    idle(RST_CYC + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wprob;
    int sel;
    int unsigned a, d;
    bit r, s, m;

    model_clear();
    // Reset, release, watch core_reset drop after RESET_CYCLES edges
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, P_ADDR, P_DATA);
    idle(5);

    // Ignored write then a passing write
    tick(1, 0, 1, I_ADDR, 5);
    idle(2);
    tick(1, 0, 1, P_ADDR, P_DATA);
    idle(3);

    // Wrong data at the pass address
    rearm();
    tick(1, 0, 1, P_ADDR, 6);
    idle(2);

    // Unexpected address
    rearm();
    tick(1, 0, 1, 100, 7);
    idle(2);

    // Start and write in the same terminal cycle: start wins
    tick(1, 1, 1, 100, 9);
    idle(RST_CYC + 2);

`ifdef RUN_CHECKER_TIMEOUT_EN
    // Deciding write in the timeout cycle wins, then a plain timeout
    for (int i = 0; i < 3 * TO_CYC && m_phase == 1 && m_cyc != TO_CYC - 1; i++)
      tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, P_ADDR, P_DATA);
    rearm();
    for (int i = 0; i < 3 * TO_CYC && m_phase == 1; i++)
      tick(1, 0, ($urandom_range(0, 3) == 0), I_ADDR, $urandom_range(0, 15));
    idle(2);
`else
    // Long idle run lets cycle_count saturate; ignored writes saturate write_count
    for (int i = 0; i < 2 * CNT_MAX + 4; i++)
      tick(1, 0, (i % 2 == 0), I_ADDR, i);
    tick(1, 0, 1, P_ADDR, P_DATA);
    rearm();
`endif

    // Reset mid-RUN discards progress
    idle(4);
    tick(0, 0, 0, 0, 0);
    idle(RST_CYC + 2);

    // Randomized traffic
    wprob = 10;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) wprob = $urandom_range(0, 30);
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 5) == 0);
      m = ($urandom_range(0, 99) < wprob);
      sel = $urandom_range(0, 3);
      if (sel < 2) begin
        a = I_ADDR; d = $urandom;
      end else if (sel == 2) begin
        a = P_ADDR; d = $urandom_range(0, 1) ? P_DATA : $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 127); d = $urandom;
      end
      tick(r, s, m, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_run_checker.md
# mips_run_checker

Synthesizable run controller and result checker for the pipelined MIPS core. It holds the core in reset for a programmable number of cycles and then releases it. It watches the core's data-memory write port and latches a sticky PASS, FAIL or TIMEOUT verdict, so the same test program can be judged on the FPGA board or in simulation. It is parameterised in bus width, reset length, timeout and the pass/ignore addresses, and can re-arm on request.

## Interface
Parameters:
- DATA_W, 32, width of writedata
- ADDR_W, 32, width of dataadr
- RESET_CYCLES, 2, cycles core_reset is held high after arming (≥1)
- TIMEOUT_CYCLES, 1000, RUN cycles before TIMEOUT (≥1)
- PASS_ADDR, 84, address whose write decides the result
- PASS_DATA, 7, data required at PASS_ADDR for PASS
- IGNORE_ADDR, 80, address whose writes are tolerated without a verdict
- CNT_W, 16, width of cycle_count and write_count

Ports:
- clk, in, 1, system clock; everything samples on rising edge
- reset, in, 1, synchronous, active-low reset of this block
- start, in, 1, re-arm pulse; honoured only in a terminal state
- memwrite, in, 1, core data-memory write strobe
- dataadr, in, ADDR_W, core write address
- writedata, in, DATA_W, core write data
- core_reset, out, 1, active-high reset driven to the core
- done, out, 1, verdict valid (sticky)
- pass, out, 1, verdict is PASS (valid when done)
- fail_code, out, 2, 0 none, 1 wrong data at PASS_ADDR, 2 unexpected address, 3 timeout
- bad_addr, out, ADDR_W, dataadr of the failing write, else 0
- bad_data, out, DATA_W, writedata of the failing write, else 0
- write_count, out, CNT_W, writes accepted in RUN, saturating
- cycle_count, out, CNT_W, cycles spent in RUN, saturating

## Operation
- States: HOLD, RUN, PASS, FAIL, TIMEOUT. The last three are terminal.
- Reset low gives state HOLD, hold counter 0, core_reset=1, and 0 on done, pass, fail_code, bad_addr, bad_data, write_count and cycle_count.
- HOLD: core_reset=1. memwrite is ignored. After RESET_CYCLES cycles with reset high, go to RUN.
- RUN: core_reset=0. cycle_count increments every cycle.
- In RUN, on memwrite=1, write_count increments, then the write is judged:
  - dataadr==PASS_ADDR && writedata==PASS_DATA: go to PASS.
  - dataadr==PASS_ADDR, other data: go to FAIL with fail_code=1.
  - dataadr==IGNORE_ADDR: stay in RUN.
  - any other address: go to FAIL with fail_code=2.
  - On FAIL, bad_addr and bad_data capture the write.
- Timeout: when cycle_count reaches TIMEOUT_CYCLES−1 with no deciding write, go to TIMEOUT with fail_code=3.
- Terminal states: done=1. pass=1 only in PASS. core_reset=0 (the core keeps running). Counters and capture registers freeze.
- start=1 in a terminal state: go to HOLD, clear every counter, verdict and capture register, and set core_reset=1.
- start in HOLD or RUN is ignored.
- Counters saturate at all-ones and never wrap.

## Timing
- A write sampled at edge N appears in the verdict outputs after edge N. Latency is 1 cycle.
- core_reset rises on the first edge with reset low. It falls exactly RESET_CYCLES edges after reset returns high or after start is accepted.
- Simultaneous deciding write and timeout in the same cycle: the write verdict wins.
- Write and start in the same terminal cycle: start wins and the write is ignored.
- Reset low mid-RUN or in a terminal state: return to HOLD on that edge and discard any verdict.
- PASS_ADDR==IGNORE_ADDR: the PASS_ADDR rules take precedence.

## Configuration
- RUN_CHECKER_TIMEOUT_EN defined: timeout comparator and TIMEOUT state are present.
- RUN_CHECKER_TIMEOUT_EN undefined: RUN lasts until a deciding write. fail_code 3 never occurs. TIMEOUT_CYCLES is unused. cycle_count still counts and saturates.

## Structure
- Package mips_run_pkg holds:
  - the state enumeration;
  - fail_code constants FC_NONE, FC_BAD_DATA, FC_BAD_ADDR, FC_TIMEOUT;
  - the 2-bit fail_code width.
- One sub-module, run_sat_counter (parameter W; inputs clr, en; output count; saturating). It is instanced for the hold counter, cycle_count and write_count.

## Test plan
- Release reset at cycle 2 with RESET_CYCLES=2 → core_reset high through 2 edges after release, then 0. State is RUN and cycle_count increments from 0.
- In RUN: write (80, 5), then (84, 7) → after the second write, write_count=2, done=1, pass=1, fail_code=0.
- In RUN: write (84, 6) → done=1, pass=0, fail_code=1, bad_addr=84, bad_data=6.
- In RUN: write (100, 7) → fail_code=2, bad_addr=100, bad_data=7.
- With RUN_CHECKER_TIMEOUT_EN and TIMEOUT_CYCLES=20, no writes → fail_code=3 once cycle_count reaches 19. A write (84, 7) in that same cycle yields PASS instead.
- From PASS, pulse start → HOLD, all outputs cleared, core_reset high for 2 cycles. Reset low mid-RUN also returns to HOLD with counters cleared.
